// File: rtl/if_id_stage_p_if.sv
// Signal bundle between fetch/hazard control and the IF/ID stage register.
// The master drives fetch data and control; the slave is the stage itself.
interface if_id_stage_p_if #(
   parameter int INSTR_WIDTH = 19,
   parameter int PC_WIDTH    = 8,
   parameter int CNT_WIDTH   = 16
);
   logic                   in_valid;
   logic [INSTR_WIDTH-1:0] next_instruction;
   logic [PC_WIDTH-1:0]    pc_plus_one_IF;
   logic                   IF_IDwrite;
   logic                   flush;
   logic                   clr_counters;
   logic [INSTR_WIDTH-1:0] instruction;
   logic [PC_WIDTH-1:0]    pc_plus_one_ID;
   logic                   valid_ID;
   logic [CNT_WIDTH-1:0]   stall_count;
   logic [CNT_WIDTH-1:0]   flush_count;

   modport master (
      output in_valid, next_instruction, pc_plus_one_IF, IF_IDwrite, flush, clr_counters,
      input  instruction, pc_plus_one_ID, valid_ID, stall_count, flush_count
   );

   modport slave (
      input  in_valid, next_instruction, pc_plus_one_IF, IF_IDwrite, flush, clr_counters,
      output instruction, pc_plus_one_ID, valid_ID, stall_count, flush_count
   );
endinterface

// File: rtl/if_id_stage_p.sv
// IF/ID pipeline register with valid bit, flush-to-bubble, stall-hold and
// saturating stall/flush event counters for performance debug.
module if_id_stage_p #(
   parameter int                     INSTR_WIDTH = 19,
   parameter int                     PC_WIDTH    = 8,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
   parameter int                     CNT_WIDTH   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   if_id_stage_p_if.slave   bus
);

   logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic                   valid_q, valid_d;
   logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
   logic                   stall_evt, flush_evt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + CNT_WIDTH'(1);
   endfunction

   always_comb begin
      instruction_d = instruction_q;
      pc_d          = pc_q;
      valid_d       = valid_q;
      if (bus.flush) begin
         // Bubble keeps the old PC+1 so decode still sees a sane value.
         instruction_d = NOP_INSTR;
         valid_d       = 1'b0;
      end else if (bus.IF_IDwrite) begin
         instruction_d = bus.in_valid ? bus.next_instruction : NOP_INSTR;
         pc_d          = bus.pc_plus_one_IF;
         valid_d       = bus.in_valid;
      end
   end

   // Only events against a real instruction are counted; flush masks stall.
   assign stall_evt = valid_q & ~bus.flush & ~bus.IF_IDwrite;
   assign flush_evt = valid_q & bus.flush;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.clr_counters) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_evt) stall_cnt_d = sat_inc(stall_cnt_q);
         if (flush_evt) flush_cnt_d = sat_inc(flush_cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instruction_q <= NOP_INSTR;
         pc_q          <= '0;
         valid_q       <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         instruction_q <= instruction_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign bus.instruction    = instruction_q;
   assign bus.pc_plus_one_ID = pc_q;
   assign bus.valid_ID       = valid_q;
   assign bus.stall_count    = stall_cnt_q;
   assign bus.flush_count    = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage_p.sv
// Directed-vector bench for if_id_stage_p: expected post-edge values are queued
// with each vector and a monitor compares them after every rising edge.
module tb_if_id_stage_p;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   if_id_stage_p_if #(.INSTR_WIDTH(19), .PC_WIDTH(8), .CNT_WIDTH(16)) bus16 ();
   if_id_stage_p_if #(.INSTR_WIDTH(19), .PC_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

   if_id_stage_p #(.INSTR_WIDTH(19), .PC_WIDTH(8), .NOP_INSTR(19'h00000), .CNT_WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16)
   );
   if_id_stage_p #(.INSTR_WIDTH(19), .PC_WIDTH(8), .NOP_INSTR(19'h00000), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );

   // The narrow-counter instance sees identical stimulus.
   assign bus4.in_valid         = bus16.in_valid;
   assign bus4.next_instruction = bus16.next_instruction;
   assign bus4.pc_plus_one_IF   = bus16.pc_plus_one_IF;
   assign bus4.IF_IDwrite       = bus16.IF_IDwrite;
   assign bus4.flush            = bus16.flush;
   assign bus4.clr_counters     = bus16.clr_counters;

   typedef struct {
      int          idx;
      logic [18:0] instr;
      logic [7:0]  pc;
      logic        vld;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   vec    = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, want);
      end
   endtask

   function automatic logic [3:0] sat4(input logic [15:0] v);
      return (v > 16'd15) ? 4'hF : v[3:0];
   endfunction

   // Monitor: the stage updates every edge, so a queued expectation is due
   // right after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instruction", e.idx, 32'(bus16.instruction), 32'(e.instr));
            chk("pc_plus_one_ID", e.idx, 32'(bus16.pc_plus_one_ID), 32'(e.pc));
            chk("valid_ID", e.idx, 32'(bus16.valid_ID), 32'(e.vld));
            chk("stall_count", e.idx, 32'(bus16.stall_count), 32'(e.sc));
            chk("flush_count", e.idx, 32'(bus16.flush_count), 32'(e.fc));
            chk("stall_count4", e.idx, 32'(bus4.stall_count), 32'(sat4(e.sc)));
            chk("flush_count4", e.idx, 32'(bus4.flush_count), 32'(sat4(e.fc)));
         end
      end
   end

   task automatic step(input logic rn, input logic iv, input logic [18:0] ni, input logic [7:0] pci,
                       input logic we, input logic fl, input logic clr,
                       input logic [18:0] e_instr, input logic [7:0] e_pc, input logic e_vld,
                       input logic [15:0] e_sc, input logic [15:0] e_fc);
      exp_t e;
      @(negedge clk);
      rst_n                  = rn;
      bus16.in_valid         = iv;
      bus16.next_instruction = ni;
      bus16.pc_plus_one_IF   = pci;
      bus16.IF_IDwrite       = we;
      bus16.flush            = fl;
      bus16.clr_counters     = clr;
      vec++;
      e.idx = vec; e.instr = e_instr; e.pc = e_pc; e.vld = e_vld; e.sc = e_sc; e.fc = e_fc;
      exp_q.push_back(e);
   endtask

   initial begin
      bus16.in_valid = 1'b0; bus16.next_instruction = '0; bus16.pc_plus_one_IF = '0;
      bus16.IF_IDwrite = 1'b0; bus16.flush = 1'b0; bus16.clr_counters = 1'b0;

      // rst iv ni pc we fl clr | instr pc vld sc fc
      step(0, 1, 19'h7FFFF, 8'hFF, 1, 0, 0, 19'h00000, 8'h00, 0, 0, 0);
      step(0, 1, 19'h7FFFF, 8'hFF, 1, 0, 0, 19'h00000, 8'h00, 0, 0, 0);
      // Loads and bubble load
      step(1, 1, 19'h12345, 8'h10, 1, 0, 0, 19'h12345, 8'h10, 1, 0, 0);
      step(1, 1, 19'h2ABCD, 8'h11, 1, 0, 0, 19'h2ABCD, 8'h11, 1, 0, 0);
      step(1, 0, 19'h3FFFF, 8'h12, 1, 0, 0, 19'h00000, 8'h12, 0, 0, 0);
      step(1, 1, 19'h12345, 8'h13, 1, 0, 0, 19'h12345, 8'h13, 1, 0, 0);
      // Stall while FULL, inputs changing
      step(1, 1, 19'h11111, 8'h20, 0, 0, 0, 19'h12345, 8'h13, 1, 1, 0);
      step(1, 0, 19'h22222, 8'h21, 0, 0, 0, 19'h12345, 8'h13, 1, 2, 0);
      step(1, 1, 19'h33333, 8'h22, 0, 0, 0, 19'h12345, 8'h13, 1, 3, 0);
      // Bubble load, then stalls while EMPTY are not counted
      step(1, 0, 19'h44444, 8'h14, 1, 0, 0, 19'h00000, 8'h14, 0, 3, 0);
      step(1, 1, 19'h55555, 8'h15, 0, 0, 0, 19'h00000, 8'h14, 0, 3, 0);
      step(1, 1, 19'h66666, 8'h16, 0, 0, 0, 19'h00000, 8'h14, 0, 3, 0);
      // Flush with stall while FULL, then flush while EMPTY
      step(1, 1, 19'h0ABCD, 8'h22, 1, 0, 0, 19'h0ABCD, 8'h22, 1, 3, 0);
      step(1, 1, 19'h55555, 8'h30, 0, 1, 0, 19'h00000, 8'h22, 0, 3, 1);
      step(1, 1, 19'h55555, 8'h31, 1, 1, 0, 19'h00000, 8'h22, 0, 3, 1);
      // 20 valid stalls: wide counter reaches 23, narrow one pins at F
      step(1, 1, 19'h1F00F, 8'h40, 1, 0, 0, 19'h1F00F, 8'h40, 1, 3, 1);
      for (int k = 1; k <= 20; k++)
         step(1, 1, 19'(k), 8'(k), 0, 0, 0, 19'h1F00F, 8'h40, 1, 16'(3 + k), 1);
      // Clear coincident with a stall wins over the increment
      step(1, 1, 19'h00777, 8'h41, 0, 0, 1, 19'h1F00F, 8'h40, 1, 0, 0);
      step(1, 1, 19'h00888, 8'h42, 0, 0, 0, 19'h1F00F, 8'h40, 1, 1, 0);
      // Reset while stalled with flush asserted, then a load
      step(0, 1, 19'h00999, 8'h43, 0, 1, 0, 19'h00000, 8'h00, 0, 0, 0);
      step(1, 1, 19'h6789A, 8'h55, 1, 0, 0, 19'h6789A, 8'h55, 1, 0, 0);
      // Clear coincident with a counted flush
      step(1, 1, 19'h7AAAA, 8'h56, 1, 1, 1, 19'h00000, 8'h55, 0, 0, 0);
      step(1, 0, 19'h00000, 8'h00, 0, 0, 0, 19'h00000, 8'h55, 0, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
